fifo_rx_credit: RTL
===================

// Module: fifo_rx_credit
// PURPOSE
//   Parametrised SpaceWire-style receive FIFO with flow-control credit management.
//   Buffers characters from the RX decoder for the host, and tracks outstanding credit.
//   Requests FCT transmission via a req/ack handshake with the TX block.
//   Flags credit violations by the far end.
//   Sits between the RX character decoder and the host read port; owns its storage array.
// PARAMETERS
//   DWIDTH      9    character width (data + control flag)
//   AWIDTH      6    address width; storage depth = 2**AWIDTH
//   MAX_CREDIT  56   max characters buffered/credited; must be <= 2**AWIDTH and a multiple of FCT_CHUNK
//   FCT_CHUNK   8    characters of credit granted per FCT
//   FCT_GAP     300  idle cycles enforced after each FCT ack before the next request
// PORTS
//   clock                  in   1         single clock, rising edge
//   reset                  in   1         asynchronous, active-high
//   wr_en                  in   1         write strobe from RX decoder, one char per cycle high
//   data_in                in   DWIDTH    character to store
//   rd_en                  in   1         host pop strobe
//   data_out               out  DWIDTH    head-of-FIFO character (first-word-fall-through)
//   f_full                 out  1         counter == MAX_CREDIT
//   f_empty                out  1         counter == 0
//   counter                out  AWIDTH+1  characters currently stored
//   credit_out             out  AWIDTH+1  credit granted to far end, not yet consumed
//   open_slot_fct          out  1         FCT request to TX
//   fct_ack                in   1         TX sent one FCT (1-cycle pulse)
//   overflow_credit_error  out  1         sticky: char received with zero credit
//   err_clr                in   1         clears overflow_credit_error
// BEHAVIOUR
//   Reset (async, any time): pointers, counter, credit_out, FSM and gap counter go to 0.
//     f_empty=1; f_full=0; open_slot_fct=0; overflow_credit_error=0; data_out=0.
//     An in-flight FCT request is dropped, with no credit granted.
//   Write is accepted when wr_en=1 and f_full=0.
//     The char is stored at wr_ptr; wr_ptr wraps mod 2**AWIDTH.
//     credit_out decrements by 1, saturating at 0.
//   Write with credit_out==0 (f_full included): overflow_credit_error<=1 on the next edge.
//     If f_full=1 the character is discarded and nothing else changes.
//   Read is accepted when rd_en=1 and f_empty=0.
//     rd_ptr advances by 1, wrapping.
//     data_out shows the new head at most 1 cycle later (registered read, FWFT).
//   rd_en with f_empty=1 is ignored; no underflow.
//   Simultaneous accepted read and write: counter unchanged; both pointers advance.
//   Flags and counter are registered and updated on the same edge as the pointers.
//   Credit invariant: counter + credit_out <= MAX_CREDIT, always.
//   FCT FSM:
//     IDLE: go to REQ when MAX_CREDIT - counter - credit_out >= FCT_CHUNK.
//     REQ: open_slot_fct=1. On fct_ack: credit_out += FCT_CHUNK, go to GAP.
//       If a write lands on the same edge as fct_ack, the net change is +FCT_CHUNK-1.
//     GAP: open_slot_fct=0; count FCT_GAP cycles, then go to IDLE.
//     fct_ack outside REQ is ignored.
//   After reset, with no traffic, the FSM grants MAX_CREDIT/FCT_CHUNK FCTs back-to-back, separated by gaps.
//   err_clr clears overflow_credit_error; a violation on the same cycle wins (flag stays 1).
// CONFIGURATION
//   FIFO_RX_ALMOST_FULL_EN defined:
//     adds parameter AF_LEVEL (default 48) and output f_almost_full.
//     f_almost_full is registered, =1 when counter >= AF_LEVEL; reset value 0.
//   FIFO_RX_ALMOST_FULL_EN undefined:
//     neither the parameter nor the port exists; all other behaviour is identical.
// TESTING
//   Reset release, idle:
//     7 FCT requests, each acked, at >= FCT_GAP+2 cycle spacing.
//     Then credit_out=56 and open_slot_fct stays 0.
//   Write 56 chars after full credit:
//     counter=56, f_full=1, credit_out=0, no error.
//     A 57th write sets overflow_credit_error; counter stays 56.
//   Read 8 from full:
//     counter=48; the FSM requests 1 FCT.
//     Ack gives credit_out=8; data_out order matches write order.
//   Simultaneous wr_en/rd_en at counter=10:
//     counter stays 10 and both pointers advance.
//     Wrap check: 200 chars through the FIFO, all match in order.
//   Assert reset in REQ with credit_out=16:
//     all outputs go to reset values in the same cycle.
//     The FCT sequence restarts from zero credit.
//   With FIFO_RX_ALMOST_FULL_EN, AF_LEVEL=48:
//     f_almost_full=1 exactly from the 48th stored char and falls on the first read.

Source files
------------

// File: rtl/fifo_rx_credit_if.sv
// Host/decoder/TX-facing signal bundle of the SpaceWire receive FIFO.
// The slave side is the FIFO; the master side is the surrounding logic or testbench.
interface fifo_rx_credit_if #(
    parameter int unsigned DWIDTH = 9,
    parameter int unsigned AWIDTH = 6
);
    logic              wr_en;
    logic [DWIDTH-1:0] data_in;
    logic              rd_en;
    logic [DWIDTH-1:0] data_out;
    logic              f_full;
    logic              f_empty;
    logic [AWIDTH:0]   counter;
    logic [AWIDTH:0]   credit_out;
    logic              open_slot_fct;
    logic              fct_ack;
    logic              overflow_credit_error;
    logic              err_clr;
`ifdef FIFO_RX_ALMOST_FULL_EN
    logic              f_almost_full;
`endif

    modport master (
        output wr_en, data_in, rd_en, fct_ack, err_clr,
`ifdef FIFO_RX_ALMOST_FULL_EN
        input  f_almost_full,
`endif
        input  data_out, f_full, f_empty, counter, credit_out,
               open_slot_fct, overflow_credit_error
    );

    modport slave (
        input  wr_en, data_in, rd_en, fct_ack, err_clr,
`ifdef FIFO_RX_ALMOST_FULL_EN
        output f_almost_full,
`endif
        output data_out, f_full, f_empty, counter, credit_out,
               open_slot_fct, overflow_credit_error
    );
endinterface

// File: rtl/fifo_rx_credit.sv
// SpaceWire receive FIFO (FWFT) with FCT credit accounting and credit-violation flag.
// Optional FIFO_RX_ALMOST_FULL_EN adds parameter AF_LEVEL and output f_almost_full.
module fifo_rx_credit #(
    parameter int unsigned DWIDTH     = 9,
    parameter int unsigned AWIDTH     = 6,
    parameter int unsigned MAX_CREDIT = 56,
    parameter int unsigned FCT_CHUNK  = 8,
    parameter int unsigned FCT_GAP    = 300
`ifdef FIFO_RX_ALMOST_FULL_EN
   ,parameter int unsigned AF_LEVEL   = 48
`endif
) (
    input logic             clk,
    input logic             rst,
    fifo_rx_credit_if.slave bus
);
    localparam int unsigned DEPTH = 2 ** AWIDTH;
    localparam int unsigned CW    = AWIDTH + 1;
    localparam int unsigned SW    = AWIDTH + 2;
    localparam int unsigned GW    = (FCT_GAP > 1) ? $clog2(FCT_GAP) : 1;

    localparam logic [CW-1:0] MAX_C    = CW'(MAX_CREDIT);
    localparam logic [CW-1:0] CHUNK_C  = CW'(FCT_CHUNK);
    localparam logic [SW-1:0] MAX_S    = SW'(MAX_CREDIT);
    localparam logic [SW-1:0] CHUNK_S  = SW'(FCT_CHUNK);
    localparam logic [GW-1:0] GAP_LAST = GW'(FCT_GAP - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_GAP  = 2'd2
    } fct_state_e;

    logic [DWIDTH-1:0] mem [DEPTH];

    logic [AWIDTH-1:0] wr_ptr_q, wr_ptr_d;
    logic [AWIDTH-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]     count_q, count_d;
    logic [CW-1:0]     credit_q, credit_d;
    logic [DWIDTH-1:0] dout_q, dout_d;
    logic              full_q, empty_q;
    logic              err_q, err_d;
`ifdef FIFO_RX_ALMOST_FULL_EN
    logic              af_q;
`endif

    fct_state_e        state_q;
    logic [GW-1:0]     gap_q;
    logic              open_q;

    logic              wr_acc;
    logic              rd_acc;
    logic              ack_take;
    logic              grant_ok;
    logic [SW-1:0]     committed;

    // Datapath next-state: pointers, occupancy, credit, error and FWFT head.
    always_comb begin
        wr_acc    = bus.wr_en & ~full_q;
        rd_acc    = bus.rd_en & ~empty_q;
        ack_take  = (state_q == S_REQ) & bus.fct_ack;

        wr_ptr_d  = wr_acc ? wr_ptr_q + AWIDTH'(1) : wr_ptr_q;
        rd_ptr_d  = rd_acc ? rd_ptr_q + AWIDTH'(1) : rd_ptr_q;

        count_d   = count_q;
        if (wr_acc && !rd_acc) begin
            count_d = count_q + CW'(1);
        end else if (rd_acc && !wr_acc) begin
            count_d = count_q - CW'(1);
        end

        credit_d  = credit_q;
        if (ack_take) begin
            credit_d = credit_d + CHUNK_C;
        end
        if (wr_acc && (credit_q != '0)) begin
            credit_d = credit_d - CW'(1);
        end

        // A violation on the same cycle as a clear leaves the flag set.
        err_d     = err_q;
        if (bus.err_clr) begin
            err_d = 1'b0;
        end
        if (bus.wr_en && (credit_q == '0)) begin
            err_d = 1'b1;
        end

        // Bypass the array when the incoming char becomes the new head.
        if (wr_acc && (wr_ptr_q == rd_ptr_d)) begin
            dout_d = bus.data_in;
        end else begin
            dout_d = mem[rd_ptr_d];
        end

        committed = SW'(count_q) + SW'(credit_q);
        grant_ok  = (committed + CHUNK_S) <= MAX_S;
    end

    always_ff @(posedge clk) begin
        if (wr_acc) begin
            mem[wr_ptr_q] <= bus.data_in;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            credit_q <= '0;
            dout_q   <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
            err_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            credit_q <= credit_d;
            dout_q   <= dout_d;
            full_q   <= (count_d == MAX_C);
            empty_q  <= (count_d == '0);
            err_q    <= err_d;
        end
    end

`ifdef FIFO_RX_ALMOST_FULL_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            af_q <= 1'b0;
        end else begin
            af_q <= (count_d >= CW'(AF_LEVEL));
        end
    end

    assign bus.f_almost_full = af_q;
`endif

    // FCT request sequencer: IDLE -> REQ (hold until ack) -> GAP (FCT_GAP cycles) -> IDLE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            gap_q   <= '0;
            open_q  <= 1'b0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (grant_ok) begin
                        state_q <= S_REQ;
                        open_q  <= 1'b1;
                    end
                end
                S_REQ: begin
                    if (bus.fct_ack) begin
                        state_q <= S_GAP;
                        open_q  <= 1'b0;
                        gap_q   <= '0;
                    end
                end
                S_GAP: begin
                    if (gap_q == GAP_LAST) begin
                        state_q <= S_IDLE;
                    end else begin
                        gap_q <= gap_q + GW'(1);
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    open_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.data_out              = dout_q;
    assign bus.f_full                = full_q;
    assign bus.f_empty               = empty_q;
    assign bus.counter               = count_q;
    assign bus.credit_out            = credit_q;
    assign bus.open_slot_fct         = open_q;
    assign bus.overflow_credit_error = err_q;
endmodule
